// File: rtl/comp_pkg.sv
// Shared definitions for the serial number-format converters:
// FSM encoding, default word width and a counter-width helper.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int COMP_W = 8;

  // Bits needed to count 0..v-1; never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_neg_bit.sv
// One bit of LSB-first two's-complement negation: bits pass through up to
// and including the first 1, every later bit is inverted.
module serial_neg_bit (
  input  logic data_bit,
  input  logic sign,
  input  logic seen_one,
  output logic res_bit,
  output logic seen_one_next
);

  assign res_bit       = (sign && seen_one) ? ~data_bit : data_bit;
  assign seen_one_next = seen_one | data_bit;

endmodule

// File: rtl/tc2sm_serial.sv
// Bit-serial two's-complement to sign-magnitude converter with valid/ready
// on both sides; one word in flight, W shift cycles per word.
module tc2sm_serial
  import comp_pkg::*;
#(
  parameter int W = COMP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_ovf,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int CW = clog2(W);

  state_t         state, state_nxt;
  logic [W-1:0]   sreg;
  logic [W-2:0]   mag;
  logic [W-1:0]   mag_nxt;
  logic [CW-1:0]  cnt;
  logic           sign, seen_one;
  logic           res_bit, seen_nxt;
  logic           accept, last;

  serial_neg_bit u_neg (
    .data_bit      (sreg[0]),
    .sign          (sign),
    .seen_one      (seen_one),
    .res_bit       (res_bit),
    .seen_one_next (seen_nxt)
  );

  // Only W-1 magnitude bits are stored; the W-th result bit goes straight
  // into the overflow flag on the final shift.
  assign mag_nxt = {res_bit, mag};
  assign accept  = in_valid && in_ready;
  assign last    = (state == SHIFT) && (cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg     <= '0;
      mag      <= '0;
      cnt      <= '0;
      sign     <= 1'b0;
      seen_one <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      if (accept) begin
        sreg     <= in_data;
        sign     <= in_data[W-1];
        cnt      <= '0;
        seen_one <= 1'b0;
      end
      if (state == SHIFT) begin
        sreg     <= sreg >> 1;
        mag      <= mag_nxt[W-1:1];
        seen_one <= seen_nxt;
        cnt      <= cnt + CW'(1);
      end
      if (last) begin
        out_data <= {sign, mag_nxt[W-2:0]};
        out_ovf  <= sign & res_bit;
      end
    end
  end

endmodule

// File: tb/tb_tc2sm_serial.sv
// Directed bench for tc2sm_serial: vector table, backpressure, mid-word
// reset and back-to-back streaming against a small reference model.
module tb_tc2sm_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_ovf;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  tc2sm_serial #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_data;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] ref_model(input logic [7:0] x);
    logic [7:0] m;
    m = x[7] ? (~x + 8'd1) : x;
    return {(x == 8'h80), x[7], m[6:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic convert(input logic [7:0] din, input logic [7:0] ed, input logic eo,
                         input string nm);
    int lat;
    wait_ready();
    in_data   = din;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = ~din;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    check({nm, "_latency"}, 32'(lat), 32'd8);
    check({nm, "_data"}, 32'(out_data), 32'(ed));
    check({nm, "_ovf"}, 32'(out_ovf), 32'(eo));
    tick();
    check({nm, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({nm, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] words[8];
    logic [8:0] r;
    int tx, rx, pend, last_t, cyc, nvalid;

    vecs[0] = '{8'h1B, 8'h1B, 1'b0};
    vecs[1] = '{8'hB7, 8'hC9, 1'b0};
    vecs[2] = '{8'hD6, 8'hAA, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 8'h81, 1'b0};
    vecs[5] = '{8'h7F, 8'h7F, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b1};
    vecs[7] = '{8'h01, 8'h01, 1'b0};
    vecs[8] = '{8'h81, 8'hFF, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 9; i++)
      convert(vecs[i].din, vecs[i].exp_data, vecs[i].exp_ovf, $sformatf("vec%0d", i));

    // Backpressure in DONE with a stray in_valid pulse during SHIFT.
    wait_ready();
    in_data = 8'hB7; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; in_data = 8'h11;
    tick(); tick();
    in_valid = 1'b1;
    tick();
    check("bp_busy_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin tick(); cyc++; end
    check("bp_reach_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data", 32'(out_data), 32'hC9);
      check("bp_hold_ovf", 32'(out_ovf), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);

    // Reset in the 4th SHIFT cycle discards the word.
    in_data = 8'hB7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) nvalid++;
      tick();
    end
    check("midrst_no_valid", 32'(nvalid), 32'd0);
    convert(8'h80, 8'h80, 1'b1, "after_rst");

    // Back-to-back stream, in_valid and out_ready held high.
    for (int i = 0; i < 8; i++) words[i] = 8'($urandom_range(0, 255));
    words[3] = 8'h80;
    tx = 0; rx = 0; pend = 0; last_t = 0;
    out_ready = 1'b1;
    in_data = words[0]; in_valid = 1'b1;
    for (cyc = 0; cyc < 200 && rx < 8; cyc++) begin
      if (in_valid && in_ready) pend = 1;
      tick();
      if (pend != 0) begin
        pend = 0;
        tx++;
        if (tx < 8) in_data = words[tx];
        else begin in_valid = 1'b0; in_data = 8'h00; end
      end
      if (out_valid) begin
        r = ref_model(words[rx]);
        check($sformatf("b2b_data%0d", rx), 32'(out_data), 32'(r[7:0]));
        check($sformatf("b2b_ovf%0d", rx), 32'(out_ovf), 32'(r[8]));
        if (rx > 0) check($sformatf("b2b_period%0d", rx), 32'(cyc - last_t), 32'd10);
        last_t = cyc;
        rx++;
      end
    end
    in_valid = 1'b0;
    check("b2b_count", 32'(rx), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tc2sm_serial.md
# tc2sm_serial

Bit-serial converter from two's-complement to sign-magnitude. It is the decode-direction partner of the 8-bit sign-magnitude → two's-complement converter. It accepts one word over a valid/ready handshake and negates negative values LSB-first, one bit per clock. It then holds the sign-magnitude result on a valid/ready output port. It sits in the arithmetic datapath wherever two's-complement results must be shown or stored as sign-magnitude.

## Interface
- W, 8, word width in bits; must be ≥ 2

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_data  in  W  two's-complement input word
- in_valid  in  1  in_data is valid
- in_ready  out  1  block can accept a word
- out_data  out  W  sign-magnitude result: sign in bit W-1, magnitude in bits W-2:0
- out_ovf  out  1  result not representable (input was -2^(W-1))
- out_valid  out  1  out_data/out_ovf are valid
- out_ready  in  1  consumer takes the result

## Operation
- States:
  - IDLE: in_ready=1.
  - SHIFT: conversion in progress.
  - DONE: out_valid=1.
- IDLE→SHIFT on in_valid&in_ready:
  - latch sign = in_data[W-1] and the word into a shift register
  - clear bit counter cnt and flag seen_one
- SHIFT, one bit per cycle, LSB first, bits 0..W-1:
  - if sign=0: copy the bit.
  - if sign=1: output the bit unchanged while seen_one=0, and set seen_one if the bit is 1; output the inverted bit once seen_one=1.
  - The result bit shifts into the magnitude register mag[W-1:0].
- SHIFT→DONE after the W-th bit (cnt=W-1):
  - out_data = {sign, mag[W-2:0]}
  - out_ovf = sign & mag[W-1]
- DONE→IDLE on out_valid&out_ready. out_data and out_ovf stay stable while out_valid=1 and out_ready=0.
- in_data is sampled only at the accept edge. Later changes have no effect.
- Zero input → out_data=0, out_ovf=0. Negative zero never appears at the output.
- Input -2^(W-1) → out_data = {1, 0…0}, out_ovf=1.
- No new word is accepted in SHIFT or DONE: in_ready=0 in those states.

## Timing
- Reset values: in_ready=0 during the reset cycle and 1 from the first cycle after rst deasserts; out_valid=0, out_data=0, out_ovf=0. State returns to IDLE.
- Latency: input accepted at edge k → out_valid=1 after edge k+W (8 cycles for W=8).
- Minimum period: W+2 cycles per word when out_ready is held high. Sequence: accept edge, W shift edges, consume edge, then in_ready rises in the following cycle.
- rst mid-SHIFT or mid-DONE: the word in flight is discarded. No out_valid pulse; all outputs return to reset values on the next edge.
- in_valid asserted while busy: ignored. The upstream must hold it until in_ready=1.
- out_ready asserted outside DONE: no effect.
- rst wins over any simultaneous handshake.

## Structure
- Shared package comp_pkg holds:
  - state encodings IDLE/SHIFT/DONE (2-bit)
  - width constant COMP_W = 8
  - counter width function clog2(W)
- Sub-module serial_neg_bit: combinational 1-bit cell.
  - Inputs: bit, sign, seen_one.
  - Outputs: res_bit, seen_one_next.
  - Instantiated once in the SHIFT datapath.
- Top level holds the FSM, cnt, the shift register, mag and the output registers.

## Test plan
- Reset, then in_data=8'b00011011 (27) with out_ready=1 → out_valid 8 cycles after accept; out_data=8'b00011011, out_ovf=0.
- in_data=8'hB7 (-73) → out_data=8'hC9, out_ovf=0. Also in_data=8'hD6 (-42) → 8'hAA.
- Boundary values:
  - 8'h00 → 8'h00, ovf=0
  - 8'hFF (-1) → 8'h81
  - 8'h7F → 8'h7F
  - 8'h80 → 8'h80, out_ovf=1
- Backpressure: out_ready=0 for 5 cycles in DONE → out_data stable and in_ready=0 throughout. Raising out_ready completes the transfer, and in_ready=1 on the next cycle. An in_valid pulse during SHIFT must not alter the result.
- Assert rst for one cycle at the 4th SHIFT cycle of 8'hB7 → no out_valid. A new 8'h80 accepted afterwards converts correctly.
- Back-to-back: 8 random words with in_valid and out_ready held high → a new result every 10 cycles, each matching the reference model (sign, |x| with ovf for -128).
